// File: rtl/sp1_ram_copier_pkg.sv
// Shared widths, opcodes and FSM encoding for the sp1_ram block copier.
package sp1_ram_copier_pkg;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = AW + 1;

  typedef logic [AW-1:0] adr_t;
  typedef logic [DW-1:0] data_t;
  typedef logic [LW-1:0] len_t;

  typedef enum logic {
    OP_COPY = 1'b0,
    OP_FILL = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/sp1_ram_copier_if.sv
// Command handshake plus sp1_ram bus; master is the copier's view.
interface sp1_ram_copier_if import sp1_ram_copier_pkg::*; ();

  logic  start;
  op_e   op;
  adr_t  src;
  adr_t  dst;
  len_t  len;
  data_t fval;
  logic  busy;
  logic  done;

  logic  cs;
  logic  we;
  adr_t  adr;
  data_t din;
  data_t dout;

  modport master (
    input  start, op, src, dst, len, fval, dout,
    output busy, done, cs, we, adr, din
  );

  modport slave (
    output start, op, src, dst, len, fval, dout,
    input  busy, done, cs, we, adr, din
  );

endinterface

// File: rtl/sp1_ram_copier_adr_gen.sv
// Loadable wrapping up/down address pointer; load and step together pre-advance the base.
module sp1_ram_copier_adr_gen
  import sp1_ram_copier_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  adr_t base_i,
  input  logic down_i,
  input  logic step_i,
  output adr_t ptr_o
);

  adr_t ptr_q, ptr_d;
  logic down_q, down_d;
  adr_t cur_c;

  always_comb begin
    cur_c  = load_i ? base_i : ptr_q;
    down_d = load_i ? down_i : down_q;
    ptr_d  = cur_c;
    if (step_i) begin
      ptr_d = down_d ? cur_c - adr_t'(1) : cur_c + adr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= '0;
      down_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      down_q <= down_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sp1_ram_copier.sv
// Block COPY/FILL initiator for sp1_ram with start/busy/done handshake.
module sp1_ram_copier
  import sp1_ram_copier_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  sp1_ram_copier_if.master  bus
);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  len_t   rem_q, rem_d;
  logic   cs_q, cs_d;
  logic   we_q, we_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  adr_t   adr_q, adr_d;
  data_t  din_q, din_d;

  logic   src_load, src_step, dst_load, dst_step;
  adr_t   src_ptr, dst_ptr;

  // Overlap-safe direction: run backwards when dst lands inside [src, src+len).
  adr_t   diff_c, len_m1_c, src_start_c, dst_start_c;
  logic   desc_c;

  always_comb begin
    diff_c      = bus.dst - bus.src;
    len_m1_c    = adr_t'(bus.len - len_t'(1));
    desc_c      = (bus.op == OP_COPY) && (diff_c != '0) && (len_t'(diff_c) < bus.len);
    src_start_c = desc_c ? bus.src + len_m1_c : bus.src;
    dst_start_c = desc_c ? bus.dst + len_m1_c : bus.dst;
  end

  sp1_ram_copier_adr_gen u_src_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (src_load),
    .base_i (src_start_c),
    .down_i (desc_c),
    .step_i (src_step),
    .ptr_o  (src_ptr)
  );

  sp1_ram_copier_adr_gen u_dst_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (dst_load),
    .base_i (dst_start_c),
    .down_i (desc_c),
    .step_i (dst_step),
    .ptr_o  (dst_ptr)
  );

  // Pointers always hold the address of the next access of their kind.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rem_d    = rem_q;
    cs_d     = 1'b0;
    we_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    adr_d    = adr_q;
    din_d    = din_q;
    src_load = 1'b0;
    src_step = 1'b0;
    dst_load = 1'b0;
    dst_step = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          rem_d    = bus.len;
          busy_d   = 1'b1;
          src_load = 1'b1;
          dst_load = 1'b1;
          if (bus.len == '0) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else if (bus.op == OP_FILL) begin
            state_d  = ST_WR;
            cs_d     = 1'b1;
            we_d     = 1'b1;
            adr_d    = dst_start_c;
            din_d    = bus.fval;
            dst_step = 1'b1;
          end else begin
            state_d  = ST_RD;
            cs_d     = 1'b1;
            adr_d    = src_start_c;
            src_step = 1'b1;
          end
        end
      end

      ST_RD: begin
        state_d  = ST_WR;
        cs_d     = 1'b1;
        we_d     = 1'b1;
        busy_d   = 1'b1;
        adr_d    = dst_ptr;
        dst_step = 1'b1;
      end

      ST_WR: begin
        rem_d = rem_q - len_t'(1);
        if (op_q == OP_COPY) begin
          din_d = bus.dout;
        end
        if (rem_q == len_t'(1)) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else if (op_q == OP_FILL) begin
          cs_d     = 1'b1;
          we_d     = 1'b1;
          busy_d   = 1'b1;
          adr_d    = dst_ptr;
          dst_step = 1'b1;
        end else begin
          state_d  = ST_RD;
          cs_d     = 1'b1;
          busy_d   = 1'b1;
          adr_d    = src_ptr;
          src_step = 1'b1;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_COPY;
      rem_q   <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      adr_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      adr_q   <= adr_d;
      din_q   <= din_d;
    end
  end

  // COPY writes forward the previous read's data straight from the RAM.
  assign bus.din  = (state_q == ST_WR && op_q == OP_COPY) ? bus.dout : din_q;
  assign bus.cs   = cs_q;
  assign bus.we   = we_q;
  assign bus.adr  = adr_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_sp1_ram_copier.sv
// Directed bench for sp1_ram_copier with a behavioural synchronous sp1_ram.
module tb_sp1_ram_copier;
  import sp1_ram_copier_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sp1_ram_copier_if bus_if ();

  sp1_ram_copier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  // RAM model with a bench-side preload port
  data_t mem [64];
  logic  tb_wr;
  adr_t  tb_adr;
  data_t tb_dat;

  always @(posedge clk) begin
    if (tb_wr) mem[tb_adr] <= tb_dat;
    else if (bus_if.cs) begin
      if (bus_if.we) mem[bus_if.adr] <= bus_if.din;
      else           bus_if.dout     <= mem[bus_if.adr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  int         tr_n;
  int         done_cyc;
  int         busy_bad;
  int         busy_c1;
  logic [6:0] tr_wa  [64];
  data_t      tr_din [64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input adr_t a, input data_t d);
    @(negedge clk);
    tb_wr = 1'b1; tb_adr = a; tb_dat = d;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  // Issue one command, record every RAM cycle until done; optionally strobe a bogus start mid-run.
  task automatic run_cmd(input op_e op, input adr_t s, input adr_t d, input len_t l,
                         input data_t fv, input bit inject);
    tr_n = 0; done_cyc = -1; busy_bad = 0; busy_c1 = 0;
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = op; bus_if.src = s; bus_if.dst = d;
    bus_if.len = l; bus_if.fval = fv;
    @(negedge clk);
    bus_if.start = 1'b0; bus_if.src = 6'h2A; bus_if.dst = 6'h15; bus_if.len = 7'd9;
    bus_if.fval = 32'h0BAD_0BAD;
    for (int c = 1; c <= 200; c++) begin
      if (c == 1) busy_c1 = int'(bus_if.busy);
      if (bus_if.cs) begin
        if (tr_n < 64) begin
          tr_wa[tr_n]  = {bus_if.we, bus_if.adr};
          tr_din[tr_n] = bus_if.din;
        end
        tr_n++;
        if (!bus_if.busy) busy_bad++;
      end
      if (bus_if.done) begin
        done_cyc = c;
        break;
      end
      if (inject && c == 2) begin
        bus_if.start = 1'b1; bus_if.op = OP_FILL; bus_if.dst = 6'h3A;
        bus_if.len = 7'd2; bus_if.fval = 32'hCAFE_F00D;
      end else begin
        bus_if.start = 1'b0;
      end
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    chk("done_seen", 64'(done_cyc > 0), 64'd1);
  endtask

  task automatic after_cmd(input string tag);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(bus_if.done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(bus_if.busy), 64'd0);
    chk({tag, "_idle_cs"},   64'(bus_if.cs),   64'd0);
  endtask

  task automatic chk_trace(input string tag, input logic [6:0] exp [8], input int n);
    chk({tag, "_ncyc"}, 64'(tr_n), 64'(n));
    for (int i = 0; i < n && i < tr_n; i++)
      chk($sformatf("%s_cyc%0d", tag, i), 64'(tr_wa[i]), 64'(exp[i]));
    chk({tag, "_busy_in_cmd"}, 64'(busy_bad), 64'd0);
  endtask

  logic [6:0] exp_fill [8] = '{7'h50, 7'h51, 7'h52, 7'h53, 7'h00, 7'h00, 7'h00, 7'h00};
  logic [6:0] exp_cpy  [8] = '{7'h00, 7'h60, 7'h01, 7'h61, 7'h02, 7'h62, 7'h03, 7'h63};
  logic [6:0] exp_ovl  [8] = '{7'h03, 7'h45, 7'h02, 7'h44, 7'h01, 7'h43, 7'h00, 7'h42};
  logic [6:0] exp_wrap [8] = '{7'h7E, 7'h7F, 7'h40, 7'h41, 7'h00, 7'h00, 7'h00, 7'h00};
  data_t      cpy_dat  [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  data_t      ovl_dat  [4] = '{32'hA, 32'hB, 32'hC, 32'hD};

  int cs_seen;

  initial begin
    rst = 1'b0; tb_wr = 1'b0; tb_adr = '0; tb_dat = '0;
    bus_if.start = 1'b0; bus_if.op = OP_COPY; bus_if.src = '0; bus_if.dst = '0;
    bus_if.len = '0; bus_if.fval = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs",   64'(bus_if.cs),   64'd0);
    chk("rst_we",   64'(bus_if.we),   64'd0);
    chk("rst_adr",  64'(bus_if.adr),  64'd0);
    chk("rst_din",  64'(bus_if.din),  64'd0);
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_done", 64'(bus_if.done), 64'd0);
    rst = 1'b1;

    // FILL 0x10..0x13
    run_cmd(OP_FILL, 6'h00, 6'h10, 7'd4, 32'hDEAD_BEEF, 1'b0);
    chk("fill_done_cyc", 64'(done_cyc), 64'd5);
    chk("fill_busy_c1", 64'(busy_c1), 64'd1);
    chk_trace("fill", exp_fill, 4);
    for (int i = 0; i < 4; i++) chk("fill_din", 64'(tr_din[i]), 64'hDEAD_BEEF);
    after_cmd("fill");
    for (int i = 0; i < 4; i++) chk($sformatf("fill_mem%0d", i), 64'(mem[6'h10 + i]), 64'hDEAD_BEEF);

    // Non-overlapping COPY with a start strobe injected while busy
    for (int i = 0; i < 4; i++) poke(adr_t'(i), cpy_dat[i]);
    run_cmd(OP_COPY, 6'h00, 6'h20, 7'd4, 32'h0, 1'b1);
    chk("cpy_done_cyc", 64'(done_cyc), 64'd9);
    chk_trace("cpy", exp_cpy, 8);
    for (int i = 0; i < 4; i++) chk($sformatf("cpy_din%0d", i), 64'(tr_din[2*i+1]), 64'(cpy_dat[i]));
    after_cmd("cpy");
    for (int i = 0; i < 4; i++) chk($sformatf("cpy_mem%0d", i), 64'(mem[6'h20 + i]), 64'(cpy_dat[i]));
    chk("cpy_no_inject", 64'(mem[6'h3A]), 64'(mem[6'h3A] === 32'hCAFE_F00D ? 32'h0 : mem[6'h3A]));

    // Overlapping COPY runs descending
    for (int i = 0; i < 4; i++) poke(adr_t'(i), ovl_dat[i]);
    run_cmd(OP_COPY, 6'h00, 6'h02, 7'd4, 32'h0, 1'b0);
    chk_trace("ovl", exp_ovl, 8);
    after_cmd("ovl");
    for (int i = 0; i < 4; i++) chk($sformatf("ovl_mem%0d", i), 64'(mem[6'h02 + i]), 64'(ovl_dat[i]));

    // FILL across the top of the address space
    run_cmd(OP_FILL, 6'h00, 6'h3E, 7'd4, 32'h1234_5678, 1'b0);
    chk_trace("wrap", exp_wrap, 4);
    chk("wrap_mem3f", 64'(mem[6'h3F]), 64'h1234_5678);
    chk("wrap_mem01", 64'(mem[6'h01]), 64'h1234_5678);
    after_cmd("wrap");

    // len=0: no RAM cycles, done the cycle after acceptance
    run_cmd(OP_FILL, 6'h00, 6'h08, 7'd0, 32'hFFFF_FFFF, 1'b0);
    chk("len0_done_cyc", 64'(done_cyc), 64'd1);
    chk("len0_ncyc", 64'(tr_n), 64'd0);
    chk("len0_busy_c1", 64'(busy_c1), 64'd1);
    after_cmd("len0");

    // Async reset mid-FILL aborts with no further writes
    for (int i = 0; i < 8; i++) poke(adr_t'(6'h30 + i), 32'h0);
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.op = OP_FILL; bus_if.dst = 6'h30; bus_if.len = 7'd8;
    bus_if.fval = 32'h55;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk("abort_cs_c1", 64'(bus_if.cs), 64'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_cs_async", 64'(bus_if.cs), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_cs",   64'(bus_if.cs),   64'd0);
      chk("abort_we",   64'(bus_if.we),   64'd0);
      chk("abort_busy", 64'(bus_if.busy), 64'd0);
      chk("abort_done", 64'(bus_if.done), 64'd0);
    end
    rst = 1'b1;
    cs_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_if.cs) cs_seen++;
    end
    chk("abort_no_resume", 64'(cs_seen), 64'd0);
    chk("abort_mem30", 64'(mem[6'h30]), 64'h55);
    chk("abort_mem31", 64'(mem[6'h31]), 64'h0);
    chk("abort_mem37", 64'(mem[6'h37]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
